// File: rtl/eth_cfg_axil_regs.sv
// AXI-Lite register bank for the Ethernet/UDP stack config. Optional scratch reg at 0x24: ETH_CFG_SCRATCH_EN.
// Latency: write commits in the cycle AW and W are both present, B the next cycle; read data 1 cycle after AR.
// Backpressure: AW/W stall while held or while B is pending; AR stalls while R is pending.
module eth_cfg_axil_regs #(
    parameter int          ADDR_WIDTH      = 8,
    parameter logic [31:0] ID_VALUE        = 32'hE7C0_0001,
    parameter logic [47:0] DEFAULT_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] DEFAULT_IP      = 32'hC0A8_0180,
    parameter logic [31:0] DEFAULT_GATEWAY = 32'hC0A8_0101,
    parameter logic [31:0] DEFAULT_SUBNET  = 32'hFFFF_FF00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axil_awaddr,
    input  logic                  axil_awvalid,
    output logic                  axil_awready,
    input  logic [31:0]           axil_wdata,
    input  logic [3:0]            axil_wstrb,
    input  logic                  axil_wvalid,
    output logic                  axil_wready,
    output logic [1:0]            axil_bresp,
    output logic                  axil_bvalid,
    input  logic                  axil_bready,
    input  logic [ADDR_WIDTH-1:0] axil_araddr,
    input  logic                  axil_arvalid,
    output logic                  axil_arready,
    output logic [31:0]           axil_rdata,
    output logic [1:0]            axil_rresp,
    output logic                  axil_rvalid,
    input  logic                  axil_rready,
    output logic [47:0]           local_mac,
    output logic [31:0]           local_ip,
    output logic [31:0]           gateway_ip,
    output logic [31:0]           subnet_mask,
    output logic                  screamer_enable,
    output logic [2:0]            udp_payload_selection,
    output logic                  clear_arp_cache,
    input  logic                  bad_fcs,
    input  logic                  fifo_overflow
);

    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] A_ID      = WW'(0);
    localparam logic [WW-1:0] A_MAC_LO  = WW'(1);
    localparam logic [WW-1:0] A_MAC_HI  = WW'(2);
    localparam logic [WW-1:0] A_IP      = WW'(3);
    localparam logic [WW-1:0] A_GW      = WW'(4);
    localparam logic [WW-1:0] A_MASK    = WW'(5);
    localparam logic [WW-1:0] A_CTRL    = WW'(6);
    localparam logic [WW-1:0] A_FCS     = WW'(7);
    localparam logic [WW-1:0] A_OVF     = WW'(8);
`ifdef ETH_CFG_SCRATCH_EN
    localparam logic [WW-1:0] A_SCRATCH = WW'(9);
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    logic          aw_held, w_held;
    logic [WW-1:0] aw_word_q;
    logic [31:0]   w_dat_q;
    logic [3:0]    w_strb_q;
    logic          aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [WW-1:0] wr_word;
    logic [31:0]   wr_dat, rd_data;
    logic [3:0]    wr_strb;
    logic [15:0]   fcs_cnt, ovf_cnt;
    logic          fcs_clr, ovf_clr;
    logic          unused_addr_lsbs;
`ifdef ETH_CFG_SCRATCH_EN
    logic [31:0]   scratch;
`endif

    assign unused_addr_lsbs = ^{axil_awaddr[1:0], axil_araddr[1:0]};

    assign axil_awready = !reset && !aw_held && !axil_bvalid;
    assign axil_wready  = !reset && !w_held && !axil_bvalid;
    assign axil_arready = !reset && !axil_rvalid;

    assign aw_hs = axil_awvalid && axil_awready;
    assign w_hs  = axil_wvalid && axil_wready;
    assign ar_hs = axil_arvalid && axil_arready;

    // A channel handshaking this cycle counts as present, so a paired AW+W commits immediately.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_word = aw_held ? aw_word_q : axil_awaddr[ADDR_WIDTH-1:2];
    assign wr_dat  = w_held ? w_dat_q : axil_wdata;
    assign wr_strb = w_held ? w_strb_q : axil_wstrb;
    assign fcs_clr = commit && (wr_word == A_FCS) && (|wr_strb);
    assign ovf_clr = commit && (wr_word == A_OVF) && (|wr_strb);

    always_comb begin
        wr_ok = (wr_word <= A_OVF);
`ifdef ETH_CFG_SCRATCH_EN
        if (wr_word == A_SCRATCH) wr_ok = 1'b1;
`endif
    end

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b1;
        case (axil_araddr[ADDR_WIDTH-1:2])
            A_ID:      rd_data = ID_VALUE;
            A_MAC_LO:  rd_data = local_mac[31:0];
            A_MAC_HI:  rd_data = {16'h0, local_mac[47:32]};
            A_IP:      rd_data = local_ip;
            A_GW:      rd_data = gateway_ip;
            A_MASK:    rd_data = subnet_mask;
            A_CTRL:    rd_data = {25'h0, udp_payload_selection, 3'h0, screamer_enable};
            A_FCS:     rd_data = {16'h0, fcs_cnt};
            A_OVF:     rd_data = {16'h0, ovf_cnt};
`ifdef ETH_CFG_SCRATCH_EN
            A_SCRATCH: rd_data = scratch;
`endif
            default:   rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_word_q   <= '0;
            w_dat_q     <= '0;
            w_strb_q    <= '0;
            axil_bvalid <= 1'b0;
            axil_bresp  <= RESP_OKAY;
            axil_rvalid <= 1'b0;
            axil_rresp  <= RESP_OKAY;
            axil_rdata  <= '0;
        end else begin
            if (commit) begin
                aw_held     <= 1'b0;
                w_held      <= 1'b0;
                axil_bvalid <= 1'b1;
                axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_word_q <= axil_awaddr[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_dat_q  <= axil_wdata;
                    w_strb_q <= axil_wstrb;
                end
                if (axil_bvalid && axil_bready) axil_bvalid <= 1'b0;
            end
            if (ar_hs) begin
                axil_rvalid <= 1'b1;
                axil_rdata  <= rd_data;
                axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (axil_rvalid && axil_rready) begin
                axil_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            local_mac             <= DEFAULT_MAC;
            local_ip              <= DEFAULT_IP;
            gateway_ip            <= DEFAULT_GATEWAY;
            subnet_mask           <= DEFAULT_SUBNET;
            screamer_enable       <= 1'b0;
            udp_payload_selection <= 3'd0;
            clear_arp_cache       <= 1'b0;
        end else begin
            clear_arp_cache <= commit && (wr_word == A_CTRL) && wr_strb[1] && wr_dat[8];
            if (commit) begin
                case (wr_word)
                    A_MAC_LO: local_mac[31:0] <= merge_bytes(local_mac[31:0], wr_dat, wr_strb);
                    A_MAC_HI: begin
                        if (wr_strb[0]) local_mac[39:32] <= wr_dat[7:0];
                        if (wr_strb[1]) local_mac[47:40] <= wr_dat[15:8];
                    end
                    A_IP:   local_ip    <= merge_bytes(local_ip, wr_dat, wr_strb);
                    A_GW:   gateway_ip  <= merge_bytes(gateway_ip, wr_dat, wr_strb);
                    A_MASK: subnet_mask <= merge_bytes(subnet_mask, wr_dat, wr_strb);
                    A_CTRL: if (wr_strb[0]) begin
                        screamer_enable       <= wr_dat[0];
                        udp_payload_selection <= wr_dat[6:4];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ETH_CFG_SCRATCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) scratch <= '0;
        else if (commit && (wr_word == A_SCRATCH)) scratch <= merge_bytes(scratch, wr_dat, wr_strb);
    end
`endif

    // Clear beats a coincident event; counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcs_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (fcs_clr) fcs_cnt <= '0;
            else if (bad_fcs && fcs_cnt != 16'hFFFF) fcs_cnt <= fcs_cnt + 16'd1;
            if (ovf_clr) ovf_cnt <= '0;
            else if (fifo_overflow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_cfg_axil_regs.sv
// Bench for eth_cfg_axil_regs: directed corner sequences, a vector table and a randomized
// register-map walk checked against a behavioural model of the register map.
module tb_eth_cfg_axil_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  axil_awaddr, axil_araddr;
    logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
    logic [31:0] axil_wdata, axil_rdata;
    logic [3:0]  axil_wstrb;
    logic [1:0]  axil_bresp, axil_rresp;
    logic        axil_bvalid, axil_bready, axil_arvalid, axil_arready, axil_rvalid, axil_rready;
    logic [47:0] local_mac;
    logic [31:0] local_ip, gateway_ip, subnet_mask;
    logic        screamer_enable, clear_arp_cache, bad_fcs, fifo_overflow;
    logic [2:0]  udp_payload_selection;

    eth_cfg_axil_regs dut (
        .clk(clk), .reset(reset),
        .axil_awaddr(axil_awaddr), .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
        .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb), .axil_wvalid(axil_wvalid),
        .axil_wready(axil_wready), .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid),
        .axil_bready(axil_bready), .axil_araddr(axil_araddr), .axil_arvalid(axil_arvalid),
        .axil_arready(axil_arready), .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
        .axil_rvalid(axil_rvalid), .axil_rready(axil_rready),
        .local_mac(local_mac), .local_ip(local_ip), .gateway_ip(gateway_ip),
        .subnet_mask(subnet_mask), .screamer_enable(screamer_enable),
        .udp_payload_selection(udp_payload_selection), .clear_arp_cache(clear_arp_cache),
        .bad_fcs(bad_fcs), .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    int   arp_pulses = 0;
    int   arp_wide   = 0;
    logic arp_prev   = 1'b0;
    always @(negedge clk) begin
        if (clear_arp_cache) arp_pulses++;
        if (clear_arp_cache && arp_prev) arp_wide++;
        arp_prev = clear_arp_cache;
    end

    // Behavioural model of the register map
    logic [47:0] m_mac;
    logic [31:0] m_ip, m_gw, m_mask, m_scratch;
    logic        m_scr;
    logic [2:0]  m_sel;
    logic [15:0] m_fcs, m_ovf;
    int          m_arp = 0;

    task automatic model_reset();
        m_mac = 48'h02_00_00_00_00_01; m_ip = 32'hC0A8_0180; m_gw = 32'hC0A8_0101;
        m_mask = 32'hFFFF_FF00; m_scratch = 0; m_scr = 0; m_sel = 0; m_fcs = 0; m_ovf = 0;
    endtask

    function automatic logic [31:0] bm(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        logic [31:0] tmp;
        resp = 2'b00;
        case (a & 8'hFC)
            8'h00: ;
            8'h04: m_mac[31:0] = bm(m_mac[31:0], d, s);
            8'h08: begin tmp = bm({16'h0, m_mac[47:32]}, d, s); m_mac[47:32] = tmp[15:0]; end
            8'h0C: m_ip = bm(m_ip, d, s);
            8'h10: m_gw = bm(m_gw, d, s);
            8'h14: m_mask = bm(m_mask, d, s);
            8'h18: begin
                if (s[0]) begin m_scr = d[0]; m_sel = d[6:4]; end
                if (s[1] && d[8]) m_arp++;
            end
            8'h1C: if (s != 0) m_fcs = 0;
            8'h20: if (s != 0) m_ovf = 0;
`ifdef ETH_CFG_SCRATCH_EN
            8'h24: m_scratch = bm(m_scratch, d, s);
`endif
            default: resp = 2'b10;
        endcase
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        d = 0;
        case (a & 8'hFC)
            8'h00: d = 32'hE7C0_0001;
            8'h04: d = m_mac[31:0];
            8'h08: d = {16'h0, m_mac[47:32]};
            8'h0C: d = m_ip;
            8'h10: d = m_gw;
            8'h14: d = m_mask;
            8'h18: d = {25'h0, m_sel, 3'b000, m_scr};
            8'h1C: d = {16'h0, m_fcs};
            8'h20: d = {16'h0, m_ovf};
`ifdef ETH_CFG_SCRATCH_EN
            8'h24: d = m_scratch;
`endif
            default: r = 2'b10;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_mac"}, local_mac, m_mac);
        check({tag, "_ip_gw"}, {local_ip, gateway_ip}, {m_ip, m_gw});
        check({tag, "_mask_ctrl"}, {subnet_mask, screamer_enable, udp_payload_selection},
              {m_mask, m_scr, m_sel});
    endtask

    // Bus tasks: entered and left 1 time unit after a rising edge.
    task automatic axil_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp);
        int t;
        logic aw_go, w_go, got;
        axil_awaddr = a; axil_wdata = d; axil_wstrb = s;
        axil_awvalid = 1; axil_wvalid = 1;
        t = 0;
        while ((axil_awvalid || axil_wvalid) && t < 100) begin
            @(negedge clk);
            aw_go = axil_awvalid && axil_awready;
            w_go  = axil_wvalid && axil_wready;
            @(posedge clk); #1;
            if (aw_go) axil_awvalid = 0;
            if (w_go) axil_wvalid = 0;
            t++;
        end
        axil_awvalid = 0; axil_wvalid = 0;
        axil_bready = 1; got = 0; resp = 2'b11; t = 0;
        while (!got && t < 100) begin
            @(negedge clk);
            if (axil_bvalid) begin resp = axil_bresp; got = 1; end
            @(posedge clk); #1;
            t++;
        end
        axil_bready = 0;
        if (!got) check("write_timeout", 0, 1);
    endtask

    task automatic axil_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        logic ar_go, got;
        axil_araddr = a; axil_arvalid = 1; axil_rready = 1;
        t = 0; ar_go = 0;
        while (!ar_go && t < 100) begin
            @(negedge clk);
            ar_go = axil_arready;
            @(posedge clk); #1;
            t++;
        end
        axil_arvalid = 0;
        got = 0; t = 0; d = 32'hxxxx_xxxx; r = 2'b11;
        while (!got && t < 100) begin
            @(negedge clk);
            if (axil_rvalid) begin d = axil_rdata; r = axil_rresp; got = 1; end
            @(posedge clk); #1;
            t++;
        end
        axil_rready = 0;
        if (!got) check("read_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    vec_t vecs[13];

    logic [7:0] addr_pool[12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                  8'h20, 8'h24, 8'h28, 8'h40};

    initial begin
        logic [1:0]  resp, mresp, rr;
        logic [31:0] rd, md;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0]  = '{8'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[1]  = '{8'h08, 32'h1234_5678, 4'hF, 2'b00, 32'h0000_5678, 2'b00};
        vecs[2]  = '{8'h08, 32'hAAAA_BBCC, 4'h2, 2'b00, 32'h0000_BB78, 2'b00};
        vecs[3]  = '{8'h00, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hE7C0_0001, 2'b00};
        vecs[4]  = '{8'h10, 32'h1122_3344, 4'h5, 2'b00, 32'hC022_0144, 2'b00};
        vecs[5]  = '{8'h14, 32'h0000_0000, 4'h0, 2'b00, 32'hFFFF_FF00, 2'b00};
        vecs[6]  = '{8'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
`ifdef ETH_CFG_SCRATCH_EN
        vecs[7]  = '{8'h24, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'hA5A5_5A5A, 2'b00};
`else
        vecs[7]  = '{8'h24, 32'hA5A5_5A5A, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
`endif
        vecs[8]  = '{8'h28, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[9]  = '{8'h18, 32'h0000_0100, 4'h1, 2'b00, 32'h0000_0000, 2'b00};
        vecs[10] = '{8'h0E, 32'h0A00_0002, 4'hF, 2'b00, 32'h0A00_0002, 2'b00};
        vecs[11] = '{8'h1F, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};
        vecs[12] = '{8'h14, 32'h00AB_0000, 4'h4, 2'b00, 32'hFFAB_FF00, 2'b00};

        reset = 1; bad_fcs = 0; fifo_overflow = 0;
        axil_awaddr = 0; axil_awvalid = 0; axil_wdata = 0; axil_wstrb = 0; axil_wvalid = 0;
        axil_bready = 0; axil_araddr = 0; axil_arvalid = 0; axil_rready = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_handshakes", {axil_awready, axil_wready, axil_arready, axil_bvalid, axil_rvalid},
              5'b0);
        check("rst_resp_data", {axil_bresp, axil_rresp, axil_rdata, clear_arp_cache}, 37'h0);
        @(posedge clk); #1;
        reset = 0;
        check_outputs("rst");

        // Read ID with exact 1-cycle latency, R held while rready is low
        axil_araddr = 8'h00; axil_arvalid = 1; axil_rready = 0;
        @(negedge clk);
        check("arready_idle", axil_arready, 1);
        @(posedge clk); #1;
        axil_arvalid = 0;
        check("rd_id_latency", {axil_rvalid, axil_rresp, axil_rdata}, {1'b1, 2'b00, 32'hE7C0_0001});
        @(posedge clk); #1;
        check("rvalid_hold", {axil_rvalid, axil_arready}, 2'b10);
        axil_rready = 1;
        @(posedge clk); #1;
        axil_rready = 0;
        check("rvalid_drop", axil_rvalid, 0);
        axil_read(8'h0C, rd, rr);
        check("rd_ip_default", {rr, rd}, {2'b00, 32'hC0A8_0180});

        // W three cycles ahead of AW, B held with bready low
        axil_wdata = 32'h0A00_0002; axil_wstrb = 4'hF; axil_wvalid = 1;
        @(negedge clk);
        check("wready_idle", axil_wready, 1);
        @(posedge clk); #1;
        axil_wvalid = 0;
        repeat (2) @(posedge clk); #1;
        check("w_held_no_commit", {axil_wready, axil_bvalid, local_ip}, {2'b00, 32'hC0A8_0180});
        axil_awaddr = 8'h0C; axil_awvalid = 1;
        @(negedge clk);
        check("awready_w_held", axil_awready, 1);
        @(posedge clk); #1;
        axil_awvalid = 0;
        check("w_first_commit", {axil_bvalid, axil_bresp, local_ip}, {1'b1, 2'b00, 32'h0A00_0002});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", {axil_bvalid, axil_awready, axil_wready}, 3'b100);
        end
        axil_bready = 1;
        @(posedge clk); #1;
        axil_bready = 0;
        check("bvalid_drop", {axil_bvalid, axil_awready}, 2'b01);
        model_write(8'h0C, 32'h0A00_0002, 4'hF, mresp);

        // Read and write of the same register in one cycle: read sees the old value
        axil_awaddr = 8'h0C; axil_wdata = 32'h0102_0304; axil_wstrb = 4'hF; axil_araddr = 8'h0C;
        axil_awvalid = 1; axil_wvalid = 1; axil_arvalid = 1;
        @(posedge clk); #1;
        axil_awvalid = 0; axil_wvalid = 0; axil_arvalid = 0;
        check("same_cycle_rd_old", {axil_rvalid, axil_rdata}, {1'b1, 32'h0A00_0002});
        check("same_cycle_wr_new", {axil_bvalid, local_ip}, {1'b1, 32'h0102_0304});
        axil_rready = 1; axil_bready = 1;
        @(posedge clk); #1;
        axil_rready = 0; axil_bready = 0;
        check("same_cycle_done", {axil_rvalid, axil_bvalid}, 2'b00);
        model_write(8'h0C, 32'h0102_0304, 4'hF, mresp);

        // CTRL: partial strobe, ARP clear pulse
        axil_write(8'h18, 32'h0000_0121, 4'b0011, resp);
        model_write(8'h18, 32'h0000_0121, 4'b0011, mresp);
        check("ctrl_wr", {resp, screamer_enable, udp_payload_selection}, {2'b00, 1'b1, 3'd2});
        check("arp_one_pulse", arp_pulses, 1);
        axil_read(8'h18, rd, rr);
        check("ctrl_rd", {rr, rd}, {2'b00, 32'h0000_0021});

        // Vector table
        for (int i = 0; i < 13; i++) begin
            axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
            axil_read(vecs[i].addr, rd, rr);
            check($sformatf("vec%0d_rd", i), {rr, rd}, {vecs[i].rresp, vecs[i].rdata});
        end
        check_outputs("vec");

        // Counters: saturation, strobe-less write, clear racing an event
        bad_fcs = 1;
        repeat (70000) @(posedge clk);
        #1 bad_fcs = 0;
        for (int i = 0; i < 3; i++) begin
            fifo_overflow = 1;
            @(posedge clk); #1 fifo_overflow = 0;
            @(posedge clk); #1;
        end
        axil_read(8'h1C, rd, rr);
        check("fcs_saturated", {rr, rd}, {2'b00, 32'h0000_FFFF});
        axil_read(8'h20, rd, rr);
        check("ovf_count", rd, 32'd3);
        axil_write(8'h20, 32'h0, 4'h0, resp);
        axil_read(8'h20, rd, rr);
        check("ovf_no_strb_kept", rd, 32'd3);
        axil_write(8'h20, 32'h0, 4'h1, resp);
        axil_read(8'h20, rd, rr);
        check("ovf_cleared", rd, 32'd0);
        axil_awaddr = 8'h1C; axil_wdata = 0; axil_wstrb = 4'b1000;
        axil_awvalid = 1; axil_wvalid = 1; bad_fcs = 1;
        @(negedge clk);
        check("clr_race_ready", {axil_awready, axil_wready}, 2'b11);
        @(posedge clk); #1;
        axil_awvalid = 0; axil_wvalid = 0; bad_fcs = 0;
        axil_bready = 1;
        @(posedge clk); #1;
        axil_bready = 0;
        axil_read(8'h1C, rd, rr);
        check("clr_beats_event", rd, 32'd0);
        m_fcs = 0; m_ovf = 0;

        // Reset with W held: nothing replayed afterwards
        axil_wdata = 32'hDEAD_0000; axil_wstrb = 4'hF; axil_wvalid = 1;
        @(posedge clk); #1;
        axil_wvalid = 0;
        reset = 1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        check_outputs("mid_rst");
        axil_awaddr = 8'h10; axil_awvalid = 1;
        @(posedge clk); #1;
        axil_awvalid = 0;
        repeat (3) @(posedge clk); #1;
        check("no_replay", {axil_bvalid, axil_wready, gateway_ip}, {2'b01, 32'hC0A8_0101});
        axil_wdata = 32'h0B0B_0B0B; axil_wvalid = 1;
        @(posedge clk); #1;
        axil_wvalid = 0;
        check("aw_first_commit", {axil_bvalid, gateway_ip}, {1'b1, 32'h0B0B_0B0B});
        axil_bready = 1;
        @(posedge clk); #1;
        axil_bready = 0;
        model_write(8'h10, 32'h0B0B_0B0B, 4'hF, mresp);

        // Randomized walk over the map
        for (int i = 0; i < 300; i++) begin
            a = addr_pool[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axil_write(a, d, s, resp);
            model_write(a, d, s, mresp);
            check($sformatf("rnd%0d_bresp_%h", i, a), resp, mresp);
            a = addr_pool[$urandom_range(0, 11)] | 8'($urandom_range(0, 3));
            axil_read(a, rd, rr);
            model_read(a, md, mresp);
            check($sformatf("rnd%0d_rd_%h", i, a), {rr, rd}, {mresp, md});
            if (i % 20 == 0) check_outputs("rnd");
        end
        check_outputs("final");
        check("arp_pulse_count", arp_pulses, m_arp);
        check("arp_pulse_width", arp_wide, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
